// File: rtl/asp_retry_engine.sv
// Authenticated security processor with ACK-based reliable transmit.
// The TX path parity-checks host words, tags them, and buffers them in a small FIFO.
// It retransmits the head frame on ACK timeout.
// The RX path verifies the tag, delivers good data to the host and returns an ACK.
module asp_retry_engine #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned TAG_SIZE  = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [TAG_SIZE-1:0]           key_in,
    input  logic                          data_parity_ready_in,
    input  logic [DATA_SIZE:0]            data_parity_in,
    output logic                          host_ready_out,
    output logic                          parity_error_out,
    output logic                          network_data_ready_out,
    output logic [DATA_SIZE+TAG_SIZE-1:0] network_data_tag_out,
    input  logic                          network_ACK_in,
    output logic                          tx_fail_out,
    input  logic                          network_data_ready_in,
    input  logic [DATA_SIZE+TAG_SIZE-1:0] network_data_tag_in,
    output logic                          host_data_ready_out,
    output logic [DATA_SIZE-1:0]          host_data_out,
    output logic                          network_ACK_out,
    output logic                          tag_error_out
);

    localparam int unsigned FRAME_W = DATA_SIZE + TAG_SIZE;
    localparam int unsigned SLICES  = DATA_SIZE / TAG_SIZE;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned TMR_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned RTY_W   = $clog2(MAX_RETRY + 2);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2
    } tx_state_t;

    // Keyed tag: XOR of all TAG_SIZE slices of the payload, folded with the key.
    function automatic logic [TAG_SIZE-1:0] calc_tag(input logic [DATA_SIZE-1:0] data,
                                                     input logic [TAG_SIZE-1:0]  key);
        logic [TAG_SIZE-1:0] acc;
        acc = key;
        for (int unsigned i = 0; i < SLICES; i++) begin
            acc = acc ^ data[i*TAG_SIZE +: TAG_SIZE];
        end
        return acc;
    endfunction

    logic [FRAME_W-1:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_nxt_c;
    tx_state_t            state;
    logic [TMR_W-1:0]     timer;
    logic [RTY_W-1:0]     retry;
    logic                 accept_c;
    logic                 parity_ok_c;
    logic                 push_c;
    logic                 pop_c;
    logic                 timeout_c;
    logic [DATA_SIZE-1:0] rx_data_c;
    logic [TAG_SIZE-1:0]  rx_tag_c;

    // Handshake, FIFO push/pop decisions and next occupancy.
    always_comb begin
        accept_c    = data_parity_ready_in && host_ready_out;
        parity_ok_c = ~(^data_parity_in);
        push_c      = accept_c && parity_ok_c;
        timeout_c   = (timer == TMR_W'(TIMEOUT - 1));
        pop_c       = (state == WAIT_ACK) &&
                      (network_ACK_in || (timeout_c && (retry == RTY_W'(MAX_RETRY))));
        rx_data_c   = network_data_tag_in[FRAME_W-1:TAG_SIZE];
        rx_tag_c    = network_data_tag_in[TAG_SIZE-1:0];
        count_nxt_c = count;
        case ({push_c, pop_c})
            2'b10:   count_nxt_c = count + CNT_W'(1);
            2'b01:   count_nxt_c = count - CNT_W'(1);
            default: count_nxt_c = count;
        endcase
    end

    // Frame storage; contents are only meaningful between push and pop.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr] <= {data_parity_in[DATA_SIZE:1],
                                 calc_tag(data_parity_in[DATA_SIZE:1], key_in)};
        end
    end

    // FIFO pointers, occupancy, host back-pressure and parity error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            host_ready_out   <= 1'b1;
            parity_error_out <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            count            <= count_nxt_c;
            host_ready_out   <= (count_nxt_c != CNT_W'(DEPTH));
            parity_error_out <= accept_c && !parity_ok_c;
        end
    end

    // TX send / wait-for-ACK / retry state machine.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                  <= IDLE;
            timer                  <= '0;
            retry                  <= '0;
            network_data_ready_out <= 1'b0;
            network_data_tag_out   <= '0;
            tx_fail_out            <= 1'b0;
        end else begin
            network_data_ready_out <= 1'b0;
            tx_fail_out            <= 1'b0;
            case (state)
                IDLE: begin
                    if (count != '0) state <= SEND;
                end
                SEND: begin
                    network_data_ready_out <= 1'b1;
                    network_data_tag_out   <= fifo_mem[rd_ptr];
                    timer                  <= '0;
                    state                  <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    timer <= timer + TMR_W'(1);
                    if (network_ACK_in) begin
                        retry <= '0;
                        state <= IDLE;
                    end else if (timeout_c) begin
                        if (retry == RTY_W'(MAX_RETRY)) begin
                            tx_fail_out <= 1'b1;
                            retry       <= '0;
                            state       <= IDLE;
                        end else begin
                            retry <= retry + RTY_W'(1);
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RX tag verification with one cycle of latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_data_ready_out <= 1'b0;
            host_data_out       <= '0;
            network_ACK_out     <= 1'b0;
            tag_error_out       <= 1'b0;
        end else begin
            host_data_ready_out <= 1'b0;
            network_ACK_out     <= 1'b0;
            tag_error_out       <= 1'b0;
            if (network_data_ready_in) begin
                if (rx_tag_c == calc_tag(rx_data_c, key_in)) begin
                    host_data_ready_out <= 1'b1;
                    host_data_out       <= rx_data_c;
                    network_ACK_out     <= 1'b1;
                end else begin
                    tag_error_out <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_asp_retry_engine.sv
// Bench for asp_retry_engine: directed scenarios plus randomized traffic against a frame-queue model.
module tb_asp_retry_engine;

    localparam int DW        = 32;
    localparam int TW        = 8;
    localparam int DEPTH     = 4;
    localparam int TIMEOUT   = 16;
    localparam int MAX_RETRY = 3;
    localparam logic [TW-1:0] KEY = 8'hA5;

    logic            clk = 1'b0;
    logic            reset;
    logic [TW-1:0]   key_in;
    logic            data_parity_ready_in;
    logic [DW:0]     data_parity_in;
    logic            host_ready_out;
    logic            parity_error_out;
    logic            network_data_ready_out;
    logic [DW+TW-1:0] network_data_tag_out;
    logic            network_ACK_in;
    logic            tx_fail_out;
    logic            network_data_ready_in;
    logic [DW+TW-1:0] network_data_tag_in;
    logic            host_data_ready_out;
    logic [DW-1:0]   host_data_out;
    logic            network_ACK_out;
    logic            tag_error_out;

    asp_retry_engine #(
        .DATA_SIZE(DW), .TAG_SIZE(TW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .key_in                 (key_in),
        .data_parity_ready_in   (data_parity_ready_in),
        .data_parity_in         (data_parity_in),
        .host_ready_out         (host_ready_out),
        .parity_error_out       (parity_error_out),
        .network_data_ready_out (network_data_ready_out),
        .network_data_tag_out   (network_data_tag_out),
        .network_ACK_in         (network_ACK_in),
        .tx_fail_out            (tx_fail_out),
        .network_data_ready_in  (network_data_ready_in),
        .network_data_tag_in    (network_data_tag_in),
        .host_data_ready_out    (host_data_ready_out),
        .host_data_out          (host_data_out),
        .network_ACK_out        (network_ACK_out),
        .tag_error_out          (tag_error_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: TX buffer as a queue of tagged frames plus the service age of the head.
    logic [DW+TW-1:0] q[$];
    bit               active;
    int               age;
    int               attempt;
    logic             exp_hready, exp_perr, exp_send, exp_fail;
    logic             exp_hvalid, exp_ackout, exp_tagerr;
    logic [DW+TW-1:0] exp_net;
    logic [DW-1:0]    exp_hdata;

    int cyc = 0, n_sends = 0, n_fails = 0, last_send = 0, send_gap = 0;
    logic [DW+TW-1:0] last_frame;

    function automatic logic [TW-1:0] ref_tag(input logic [DW-1:0] d);
        return d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0] ^ KEY;
    endfunction

    task automatic model_reset();
        q.delete();
        active = 0; age = 0; attempt = 0;
        exp_hready = 1'b1; exp_perr = 1'b0; exp_send = 1'b0; exp_fail = 1'b0;
        exp_hvalid = 1'b0; exp_ackout = 1'b0; exp_tagerr = 1'b0;
        exp_net = '0; exp_hdata = '0;
    endtask

    // One clock edge of the model, using the inputs the DUT just sampled.
    task automatic model_step();
        int  sz;
        bit  pop;
        bit  acc;
        sz = q.size();
        pop = 0;
        exp_perr = 1'b0; exp_send = 1'b0; exp_fail = 1'b0;
        exp_hvalid = 1'b0; exp_ackout = 1'b0; exp_tagerr = 1'b0;
        // Head service: one cycle to launch, then TIMEOUT cycles of listening per attempt.
        if (!active) begin
            if (sz > 0) begin active = 1; age = 0; attempt = 0; end
        end else begin
            age++;
            if (age == 1) begin
                exp_send = 1'b1;
                exp_net  = q[0];
            end else if (network_ACK_in) begin
                pop = 1; active = 0;
            end else if (age == TIMEOUT + 1) begin
                if (attempt < MAX_RETRY) begin
                    attempt++; age = 0;
                end else begin
                    pop = 1; exp_fail = 1'b1; active = 0;
                end
            end
        end
        acc = data_parity_ready_in && (sz != DEPTH);
        if (acc && (^data_parity_in) == 1'b1) exp_perr = 1'b1;
        if (pop) void'(q.pop_front());
        if (acc && (^data_parity_in) == 1'b0)
            q.push_back({data_parity_in[DW:1], ref_tag(data_parity_in[DW:1])});
        exp_hready = (q.size() != DEPTH);
        if (network_data_ready_in) begin
            if (network_data_tag_in[TW-1:0] == ref_tag(network_data_tag_in[DW+TW-1:TW])) begin
                exp_hvalid = 1'b1; exp_ackout = 1'b1;
                exp_hdata  = network_data_tag_in[DW+TW-1:TW];
            end else begin
                exp_tagerr = 1'b1;
            end
        end
    endtask

    task automatic compare_outputs();
        check("host_ready", 64'(host_ready_out), 64'(exp_hready));
        check("parity_err", 64'(parity_error_out), 64'(exp_perr));
        check("net_valid", 64'(network_data_ready_out), 64'(exp_send));
        check("net_frame", 64'(network_data_tag_out), 64'(exp_net));
        check("tx_fail", 64'(tx_fail_out), 64'(exp_fail));
        check("host_valid", 64'(host_data_ready_out), 64'(exp_hvalid));
        check("host_data", 64'(host_data_out), 64'(exp_hdata));
        check("net_ack", 64'(network_ACK_out), 64'(exp_ackout));
        check("tag_err", 64'(tag_error_out), 64'(exp_tagerr));
        if (network_data_ready_out === 1'b1) begin
            send_gap   = cyc - last_send;
            last_send  = cyc;
            last_frame = network_data_tag_out;
            n_sends++;
        end
        if (tx_fail_out === 1'b1) n_fails++;
    endtask

    task automatic step(input logic dv, input logic [DW:0] dp, input logic ack,
                        input logic rv, input logic [DW+TW-1:0] rd);
        @(negedge clk);
        compare_outputs();
        data_parity_ready_in  = dv;
        data_parity_in        = dp;
        network_ACK_in        = ack;
        network_data_ready_in = rv;
        network_data_tag_in   = rd;
        @(posedge clk);
        cyc++;
        model_step();
    endtask

    task automatic idle(input logic ack);
        step(1'b0, 33'h0, ack, 1'b0, 40'h0);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p);
        step(1'b1, {d, p}, 1'b0, 1'b0, 40'h0);
    endtask

    task automatic pulse_reset(input int hold);
        @(negedge clk);
        reset                 = 1'b0;
        data_parity_ready_in  = 1'b0;
        data_parity_in        = '0;
        network_ACK_in        = 1'b0;
        network_data_ready_in = 1'b0;
        network_data_tag_in   = '0;
        model_reset();
        #1;
        compare_outputs();
        repeat (hold) begin
            @(negedge clk);
            compare_outputs();
        end
        reset = 1'b1;
    endtask

    task automatic rand_step(input int dv_pct, input int ack_pct);
        logic [DW-1:0]    d;
        logic [DW-1:0]    rdat;
        logic [DW+TW-1:0] rx;
        logic             p;
        d = $urandom;
        p = ^d;
        if ($urandom_range(99) < 20) p = ~p;
        rdat = $urandom;
        rx = {rdat, ref_tag(rdat)};
        if ($urandom_range(99) < 40) rx[TW-1:0] = rx[TW-1:0] ^ 8'(1 << $urandom_range(7));
        step(($urandom_range(99) < dv_pct), {d, p}, ($urandom_range(99) < ack_pct),
             ($urandom_range(99) < 50), rx);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, f0, k, accepted;
        logic hr;
        logic [DW-1:0] d;
        key_in = KEY;
        reset  = 1'b0;
        data_parity_ready_in = 1'b0; data_parity_in = '0; network_ACK_in = 1'b0;
        network_data_ready_in = 1'b0; network_data_tag_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_outputs();
        reset = 1'b1;

        // Good frame, ACK a few cycles after it goes out.
        send_frame(32'h12345678, 1'b1);
        s0 = n_sends; k = 0;
        while (n_sends == s0 && k < 10) begin idle(1'b0); k++; end
        check("t1_sent", 64'(n_sends - s0), 64'd1);
        check("t1_frame", 64'(last_frame), 64'h12345678AD);
        idle(1'b0); idle(1'b0); idle(1'b1);
        repeat (30) idle(1'b0);
        check("t1_single_send", 64'(n_sends - s0), 64'd1);

        // Bad parity frame.
        s0 = n_sends;
        send_frame(32'h12345678, 1'b0);
        #1;
        check("t2_perr", 64'(parity_error_out), 64'd1);
        repeat (20) idle(1'b0);
        check("t2_no_send", 64'(n_sends - s0), 64'd0);
        check("t2_ready", 64'(host_ready_out), 64'd1);

        // No ACK ever: four sends 17 cycles apart, then one failure.
        pulse_reset(2);
        s0 = n_sends; f0 = n_fails;
        send_frame(32'hCAFEF00D, ^32'hCAFEF00D);
        repeat (80) idle(1'b0);
        check("t3_sends", 64'(n_sends - s0), 64'd4);
        check("t3_gap", 64'(send_gap), 64'd17);
        check("t3_fail", 64'(n_fails - f0), 64'd1);

        // Five frames back to back without ACK: the fifth waits for the first pop.
        pulse_reset(2);
        f0 = n_fails; accepted = 0; k = 0;
        while (accepted < 5 && k < 200) begin
            d = 32'h1000_0000 + 32'(accepted);
            #1;
            hr = host_ready_out;
            send_frame(d, ^d);
            if (hr) begin
                accepted++;
                if (accepted == 4) begin
                    #1;
                    check("t4_full", 64'(host_ready_out), 64'd0);
                end
                if (accepted == 5) check("t4_after_pop", 64'(n_fails - f0), 64'd1);
            end
            k++;
        end
        check("t4_all_accepted", 64'(accepted), 64'd5);

        // RX good and bad tag.
        step(1'b0, 33'h0, 1'b0, 1'b1, 40'h12345678AD);
        #1;
        check("t5_hvalid", 64'(host_data_ready_out), 64'd1);
        check("t5_hdata", 64'(host_data_out), 64'h12345678);
        check("t5_ack", 64'(network_ACK_out), 64'd1);
        step(1'b0, 33'h0, 1'b0, 1'b1, 40'h12345678AC);
        #1;
        check("t5_tagerr", 64'(tag_error_out), 64'd1);
        check("t5_no_hvalid", 64'(host_data_ready_out), 64'd0);
        check("t5_no_ack", 64'(network_ACK_out), 64'd0);
        check("t5_hold", 64'(host_data_out), 64'h12345678);

        // ACK arriving on the timeout cycle wins.
        pulse_reset(2);
        f0 = n_fails;
        send_frame(32'h0BADBEEF, ^32'h0BADBEEF);
        k = 0;
        while (!(active && age == TIMEOUT) && k < 40) begin idle(1'b0); k++; end
        check("t6_reach_timeout", 64'(k < 40), 64'd1);
        s0 = n_sends;
        idle(1'b1);
        repeat (30) idle(1'b0);
        check("t6_no_resend", 64'(n_sends - s0), 64'd0);
        check("t6_no_fail", 64'(n_fails - f0), 64'd0);

        // Reset during WAIT_ACK discards the frame.
        send_frame(32'h55AA33CC, ^32'h55AA33CC);
        k = 0;
        while (!(active && age >= 4) && k < 20) begin idle(1'b0); k++; end
        pulse_reset(3);
        s0 = n_sends;
        repeat (40) idle(1'b0);
        check("t6_rst_no_send", 64'(n_sends - s0), 64'd0);

        // Randomized traffic.
        repeat (500) rand_step(50, 12);
        pulse_reset(1);
        repeat (300) rand_step(70, 0);
        repeat (40) rand_step(60, 5);
        pulse_reset(2);
        repeat (300) rand_step(40, 35);
        idle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
